// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared state encoding and BCD limits for the stopwatch core.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } sw_state_t;

   localparam int BCD_W        = 4;
   localparam int SEC_TENS_MAX = 5;
   localparam int MIN_TENS_MAX = 5;
   localparam int UNITS_MAX    = 9;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Purpose  : One modulo-(MAX+1) BCD digit with same-cycle carry out.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter int MAX = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [BCD_W-1:0] q,
   output logic             carry
);

   logic [BCD_W-1:0] q_q;
   logic [BCD_W-1:0] q_d;

   // Wrapping on >= MAX keeps the digit inside its modulus whatever state it holds.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = (q_q >= BCD_W'(MAX)) ? '0 : q_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign carry = en && (q_q == BCD_W'(MAX));

endmodule : bcd_digit
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_counter
// Purpose  : MM:SS BCD stopwatch with start/stop/clear control, 1 Hz enable.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter bit HOLD_AT_MAX = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             start_stop,
   input  logic             clear,
   output logic [BCD_W-1:0] sec_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] min_tens,
   output logic             running,
   output logic             overflow
);

   sw_state_t        state_q, state_d;
   logic             running_q, running_d;
   logic             overflow_q, overflow_d;

   logic [3:0]       en;
   logic [3:0]       carry;
   logic [BCD_W-1:0] q [4];
   logic             count;
   logic             at_max;
   logic             wrap;

   assign count  = tick && (state_q == RUNNING);
   assign at_max = (q[3] == BCD_W'(MIN_TENS_MAX)) && (q[2] == BCD_W'(UNITS_MAX)) &&
                   (q[1] == BCD_W'(SEC_TENS_MAX)) && (q[0] == BCD_W'(UNITS_MAX));
   assign wrap   = count && at_max;

   // Holding at 59:59 is done by never enabling the first stage.
   assign en = {carry[2:0], count && !(HOLD_AT_MAX && at_max)};

   generate
      for (genvar i = 0; i < 4; i++) begin : g_digit
         localparam int DIGIT_MAX = (i == 1 || i == 3) ? SEC_TENS_MAX : UNITS_MAX;
         bcd_digit #(
            .MAX   (DIGIT_MAX)
         ) u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear),
            .en    (en[i]),
            .q     (q[i]),
            .carry (carry[i])
         );
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else if (start_stop) begin
         unique case (state_q)
            IDLE:    state_d = RUNNING;
            RUNNING: state_d = PAUSED;
            PAUSED:  state_d = RUNNING;
            default: state_d = IDLE;
         endcase
      end else if (HOLD_AT_MAX && wrap) begin
         state_d = PAUSED;
      end
      running_d  = (state_d == RUNNING);
      overflow_d = !clear && (HOLD_AT_MAX ? wrap : carry[3]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         running_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         running_q  <= running_d;
         overflow_q <= overflow_d;
      end
   end

   assign sec_ones = q[0];
   assign sec_tens = q[1];
   assign min_ones = q[2];
   assign min_tens = q[3];
   assign running  = running_q;
   assign overflow = overflow_q;

endmodule : stopwatch_counter
`default_nettype wire
